// File: rtl/can_form_checker.sv
// Form-error monitor for the CAN receive path: checks CRC delimiter, ACK delimiter and EOF
// bits at a programmable sample point. Optional saturating counter under FORM_ERR_COUNT_EN.
module can_form_checker #(
  parameter int CLKS_PER_BIT  = 10,
  parameter int SAMPLE_POINT  = 7,
  parameter int EST_CRC_DELIM = 9,
  parameter int EST_ACK_DELIM = 10,
  parameter int EST_EOF       = 20,
  parameter int EOF_BITS      = 7,
  parameter int RX_MODE       = 1,
  parameter int CNT_W         = 8
) (
  input  logic             Clock_TB,
  input  logic             Reset,
  input  logic             Bit_Entrada,
  input  logic [0:5]       Estado,
  input  logic             Clear,
  output logic             Form_monitor,
  output logic [1:0]       Form_field,
  output logic             Form_sticky,
  output logic             Overload_flag,
  output logic [2:0]       Eof_bit_idx
`ifdef FORM_ERR_COUNT_EN
  ,
  output logic [CNT_W-1:0] Error_count
`endif
);

  typedef enum logic [1:0] {
    FIELD_NONE = 2'b00,
    FIELD_CRC  = 2'b01,
    FIELD_ACK  = 2'b10,
    FIELD_EOF  = 2'b11
  } field_e;

  localparam int PH_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [0:5]      CRC_CODE   = 6'(EST_CRC_DELIM);
  localparam logic [0:5]      ACK_CODE   = 6'(EST_ACK_DELIM);
  localparam logic [0:5]      EOF_CODE   = 6'(EST_EOF);
  localparam logic [2:0]      EOF_LAST   = 3'(EOF_BITS - 1);
  localparam logic [PH_W-1:0] PH_LAST    = PH_W'(CLKS_PER_BIT - 1);
  localparam logic [PH_W-1:0] PH_SAMPLE  = PH_W'(SAMPLE_POINT);
  localparam logic            RX_RECEIVE = (RX_MODE != 0);

  // An illegal parameter set stops elaboration instead of silently misbehaving.
  if (CLKS_PER_BIT < 2 || SAMPLE_POINT < 0 || SAMPLE_POINT >= CLKS_PER_BIT ||
      EOF_BITS < 1 || EOF_BITS > 8 || CNT_W < 1) begin : g_bad_params
    $error("can_form_checker: illegal parameter set");
  end

  logic [0:5]      Estado_q;
  logic [PH_W-1:0] bit_cnt;
  logic [PH_W-1:0] bit_cnt_next;
  logic [PH_W-1:0] phase;
  logic [2:0]      eof_idx_next;
  logic            in_crc, in_ack, in_eof;
  logic            sample, dominant_sample, last_eof;
  logic            overload_hit, form_hit;
  field_e          hit_field;

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    phase        = (Estado != Estado_q) ? '0 : bit_cnt;
    bit_cnt_next = (phase == PH_LAST) ? '0 : phase + PH_W'(1);

    in_crc   = (Estado == CRC_CODE);
    in_ack   = (Estado == ACK_CODE);
    in_eof   = (Estado == EOF_CODE);
    last_eof = (Eof_bit_idx == EOF_LAST);

    sample          = (phase == PH_SAMPLE);
    dominant_sample = sample && !Bit_Entrada;

    // A receiver sees dominant on the last EOF bit as an overload request, not a form error.
    overload_hit = dominant_sample && in_eof && RX_RECEIVE && last_eof;
    form_hit     = dominant_sample && (in_crc || in_ack || in_eof) && !overload_hit;

    hit_field = FIELD_NONE;
    if (in_crc)      hit_field = FIELD_CRC;
    else if (in_ack) hit_field = FIELD_ACK;
    else if (in_eof) hit_field = FIELD_EOF;

    eof_idx_next = Eof_bit_idx;
    if (!in_eof)                        eof_idx_next = '0;
    else if (phase == PH_LAST && !last_eof) eof_idx_next = Eof_bit_idx + 3'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock_TB or posedge Reset) begin
    if (Reset) begin
      Estado_q      <= '0;
      bit_cnt       <= '0;
      Eof_bit_idx   <= '0;
      Form_monitor  <= 1'b0;
      Overload_flag <= 1'b0;
      Form_field    <= FIELD_NONE;
      Form_sticky   <= 1'b0;
    end else begin
      Estado_q      <= Estado;
      bit_cnt       <= bit_cnt_next;
      Eof_bit_idx   <= eof_idx_next;
      Form_monitor  <= form_hit;
      Overload_flag <= overload_hit;
      // A new error outranks a coincident Clear.
      if (form_hit) begin
        Form_field  <= hit_field;
        Form_sticky <= 1'b1;
      end else if (Clear) begin
        Form_field  <= FIELD_NONE;
        Form_sticky <= 1'b0;
      end
    end
  end

`ifdef FORM_ERR_COUNT_EN
  always_ff @(posedge Clock_TB or posedge Reset) begin
    if (Reset) begin
      Error_count <= '0;
    end else if (form_hit) begin
      if (Clear)             Error_count <= CNT_W'(1);
      else if (~&Error_count) Error_count <= Error_count + CNT_W'(1);
    end else if (Clear) begin
      Error_count <= '0;
    end
  end
`endif

  a_pulses_exclusive: assert property (@(posedge Clock_TB) disable iff (Reset)
    !(Form_monitor && Overload_flag));

endmodule

// File: tb/tb_can_form_checker.sv
// Scoreboard bench for can_form_checker: default receiver, transmitter (RX_MODE=0) and
// narrow-counter (CNT_W=2) instances share one stimulus stream.
module tb_can_form_checker;

  typedef struct packed {
    logic       mon;
    logic       ovl;
    logic [1:0] field;
    logic       sticky;
    logic [2:0] idx;
  } obs_t;

  localparam logic [0:5] EST_IDLE = 6'd0;
  localparam logic [0:5] EST_OTHER = 6'd5;
  localparam logic [0:5] EST_CRC  = 6'd9;
  localparam logic [0:5] EST_ACK  = 6'd10;
  localparam logic [0:5] EST_EOF  = 6'd20;

  logic       Clock_TB = 1'b0;
  logic       Reset = 1'b1;
  logic       Bit_Entrada = 1'b1;
  logic [0:5] Estado = EST_IDLE;
  logic       Clear = 1'b0;

  logic [2:0] mon, ovl, stk;
  logic [1:0] fld [3];
  logic [2:0] idx [3];
`ifdef FORM_ERR_COUNT_EN
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
`endif

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 Clock_TB = ~Clock_TB;

  can_form_checker u_rx (
    .Clock_TB(Clock_TB), .Reset(Reset), .Bit_Entrada(Bit_Entrada), .Estado(Estado), .Clear(Clear),
    .Form_monitor(mon[0]), .Form_field(fld[0]), .Form_sticky(stk[0]),
    .Overload_flag(ovl[0]), .Eof_bit_idx(idx[0])
`ifdef FORM_ERR_COUNT_EN
    , .Error_count(cnt0)
`endif
  );

  can_form_checker #(.RX_MODE(0)) u_tx (
    .Clock_TB(Clock_TB), .Reset(Reset), .Bit_Entrada(Bit_Entrada), .Estado(Estado), .Clear(Clear),
    .Form_monitor(mon[1]), .Form_field(fld[1]), .Form_sticky(stk[1]),
    .Overload_flag(ovl[1]), .Eof_bit_idx(idx[1])
`ifdef FORM_ERR_COUNT_EN
    , .Error_count(cnt1)
`endif
  );

  can_form_checker #(.CNT_W(2)) u_c2 (
    .Clock_TB(Clock_TB), .Reset(Reset), .Bit_Entrada(Bit_Entrada), .Estado(Estado), .Clear(Clear),
    .Form_monitor(mon[2]), .Form_field(fld[2]), .Form_sticky(stk[2]),
    .Overload_flag(ovl[2]), .Eof_bit_idx(idx[2])
`ifdef FORM_ERR_COUNT_EN
    , .Error_count(cnt2)
`endif
  );

  function automatic obs_t obs(input int s);
    return '{mon: mon[s], ovl: ovl[s], field: fld[s], sticky: stk[s], idx: idx[s]};
  endfunction

  function automatic obs_t mk(input logic m, input logic o, input logic [1:0] f,
                              input logic s, input logic [2:0] i);
    return '{mon: m, ovl: o, field: f, sticky: s, idx: i};
  endfunction

  // Apply one cycle of inputs, then return #1 after the rising edge that consumed them.
  task automatic drive(input logic b, input logic [0:5] e, input logic c);
    Bit_Entrada = b;
    Estado      = e;
    Clear       = c;
    @(posedge Clock_TB);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b1, EST_IDLE, 1'b0);
  endtask

  task automatic clear_all();
    drive(1'b1, EST_IDLE, 1'b1);
  endtask

  task automatic test_reset();
    obs_t got;
    Reset = 1'b1;
    repeat (3) @(posedge Clock_TB);
    #1;
    for (int s = 0; s < 3; s++) begin
      got = obs(s);
      n_cmp++;
      if (got !== mk(0, 0, 2'b00, 0, 3'd0)) begin
        n_bad++;
        $display("FAIL reset_state[dut%0d]: got %p expected all zero", s, got);
      end
    end
`ifdef FORM_ERR_COUNT_EN
    n_cmp++;
    if (cnt0 !== 8'd0 || cnt2 !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_count: got %0d/%0d expected 0/0", cnt0, cnt2);
    end
`endif
    Reset = 1'b0;
  endtask

  task automatic test_crc_delim();
    obs_t got, want;
    clear_all();
    idle(1);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(mk(i == 7, 0, (i >= 7) ? 2'b01 : 2'b00, i >= 7, 3'd0));
      drive(1'b0, EST_CRC, 1'b0);
      got = obs(0); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL crc_delim[%0d]: got %p expected %p", i, got, want);
      end
    end
  endtask

  // Second pass is dominant off the sample point: no pulse, held outputs untouched.
  task automatic test_ack_delim();
    obs_t got, want;
    clear_all();
    idle(1);
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 10; i++) begin
        if (pass == 0) exp_q.push_back(mk(i == 7, 0, (i >= 7) ? 2'b10 : 2'b00, i >= 7, 3'd0));
        else           exp_q.push_back(mk(0, 0, 2'b10, 1, 3'd0));
        drive((pass == 0) ? (i != 7) : (i != 6), EST_ACK, 1'b0);
        got = obs(0); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL ack_delim[p%0d c%0d]: got %p expected %p", pass, i, got, want);
        end
      end
      idle(1);
    end
  endtask

  task automatic test_eof_rx();
    obs_t got, want;
    int   e_idx;
    clear_all();
    idle(1);
    for (int i = 0; i < 70; i++) begin
      e_idx = ((i + 1) / 10 > 6) ? 6 : (i + 1) / 10;
      exp_q.push_back(mk(i == 37, i == 67, (i >= 37) ? 2'b11 : 2'b00, i >= 37, 3'(e_idx)));
      drive(!(i == 37 || i == 67), EST_EOF, 1'b0);
      got = obs(0); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL eof_rx[%0d]: got %p expected %p", i, got, want);
      end
    end
    exp_q.push_back(mk(0, 0, 2'b11, 1, 3'd0));
    drive(1'b1, EST_IDLE, 1'b0);
    got = obs(0); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL eof_idx_leave: got %p expected %p", got, want);
    end
  endtask

  task automatic test_eof_tx();
    obs_t got, want;
    int   e_idx;
    clear_all();
    idle(1);
    for (int i = 0; i < 70; i++) begin
      e_idx = ((i + 1) / 10 > 6) ? 6 : (i + 1) / 10;
      exp_q.push_back(mk(i == 67, 0, (i >= 67) ? 2'b11 : 2'b00, i >= 67, 3'(e_idx)));
      drive(i != 67, EST_EOF, 1'b0);
      got = obs(1); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL eof_tx[%0d]: got %p expected %p", i, got, want);
      end
    end
  endtask

  task automatic test_counter();
    obs_t got, want;
    int   cnt_tab [6] = '{1, 2, 3, 3, 3, 1};
    int   cnt_want;
    clear_all();
    for (int e = 0; e < 6; e++) begin
      idle(1);
      for (int i = 0; i < 10; i++) begin
        exp_q.push_back(mk(i == 7, 0, (e > 0 || i >= 7) ? 2'b01 : 2'b00, e > 0 || i >= 7, 3'd0));
        drive(i != 7, EST_CRC, (e == 5 && i == 7));
        got = obs(2); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL counter_obs[e%0d c%0d]: got %p expected %p", e, i, got, want);
        end
`ifdef FORM_ERR_COUNT_EN
        cnt_want = (i >= 7) ? cnt_tab[e] : ((e == 0) ? 0 : cnt_tab[e-1]);
        n_cmp++;
        if (cnt2 !== 2'(cnt_want)) begin
          n_bad++;
          $display("FAIL counter_val[e%0d c%0d]: got %0d expected %0d", e, i, cnt2, cnt_want);
        end
`else
        cnt_want = cnt_tab[e];
`endif
      end
    end
    clear_all();
    got = obs(2); n_cmp++;
    if (got !== mk(0, 0, 2'b00, 0, 3'd0)) begin
      n_bad++;
      $display("FAIL clear_only: got %p expected all zero", got);
    end
`ifdef FORM_ERR_COUNT_EN
    n_cmp++;
    if (cnt2 !== 2'd0) begin
      n_bad++;
      $display("FAIL clear_count: got %0d expected 0", cnt2);
    end
`endif
  endtask

  task automatic test_back_to_back();
    obs_t got, want;
    clear_all();
    idle(1);
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(mk(i == 7 || i == 17, 0,
                         (i >= 17) ? 2'b10 : ((i >= 7) ? 2'b01 : 2'b00), i >= 7, 3'd0));
      drive(!(i == 7 || i == 17), (i < 10) ? EST_CRC : EST_ACK, 1'b0);
      got = obs(0); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL back_to_back[%0d]: got %p expected %p", i, got, want);
      end
    end
  endtask

  // State change after 4 cycles restarts the phase: only the new state's sample counts.
  task automatic test_midbit_change();
    obs_t got, want;
    clear_all();
    idle(1);
    for (int i = 0; i < 14; i++) begin
      exp_q.push_back(mk(i == 11, 0, (i >= 11) ? 2'b01 : 2'b00, i >= 11, 3'd0));
      drive(!(i == 7 || i == 11), (i < 4) ? EST_ACK : EST_CRC, 1'b0);
      got = obs(0); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL midbit_change[%0d]: got %p expected %p", i, got, want);
      end
    end
  endtask

  task automatic test_unchecked();
    obs_t got, want;
    clear_all();
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(mk(0, 0, 2'b00, 0, 3'd0));
      drive(1'b0, EST_OTHER, 1'b0);
      got = obs(0); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL unchecked_state[%0d]: got %p expected %p", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_bit();
    obs_t got, want;
    clear_all();
    idle(1);
    for (int i = 0; i < 10; i++) drive(i != 7, EST_CRC, 1'b0);
    idle(1);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(0, 0, 2'b01, 1, 3'd0));
      drive(1'b0, EST_CRC, 1'b0);
      got = obs(0); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL pre_reset[%0d]: got %p expected %p", i, got, want);
      end
    end
    #2 Reset = 1'b1;
    #1;
    got = obs(0); n_cmp++;
    if (got !== mk(0, 0, 2'b00, 0, 3'd0)) begin
      n_bad++;
      $display("FAIL reset_async: got %p expected all zero", got);
    end
    @(posedge Clock_TB);
    #1 Reset = 1'b0;
    for (int j = 0; j < 10; j++) begin
      exp_q.push_back(mk(j == 7, 0, (j >= 7) ? 2'b01 : 2'b00, j >= 7, 3'd0));
      drive(1'b0, EST_CRC, 1'b0);
      got = obs(0); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL post_reset[%0d]: got %p expected %p", j, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_crc_delim();
    test_ack_delim();
    test_eof_rx();
    test_eof_tx();
    test_counter();
    test_back_to_back();
    test_midbit_change();
    test_unchecked();
    test_reset_mid_bit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no completion expected $finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/can_form_checker.md
Name: can_form_checker

Overview:
- Parametrised form-error monitor for the CAN receive path.
- Checks the fixed-form fields (CRC delimiter, ACK delimiter, End Of Frame) at a programmable sample point inside each bit, using the decoder state code `Estado`.
- Reports which field failed, tracks the EOF bit index, flags an overload condition on the last EOF bit in receiver mode, and keeps a sticky flag plus a saturating error count.
- Sits beside the frame decoder FSM and feeds the error-handling/error-frame logic.

Parameters:
- CLKS_PER_BIT, 10, clocks per nominal CAN bit (>=2).
- SAMPLE_POINT, 7, clock phase within the bit at which `Bit_Entrada` is sampled (0..CLKS_PER_BIT-1).
- EST_CRC_DELIM, 9, `Estado` code of the CRC delimiter.
- EST_ACK_DELIM, 10, `Estado` code of the ACK delimiter.
- EST_EOF, 20, `Estado` code of End Of Frame.
- EOF_BITS, 7, number of EOF bits.
- RX_MODE, 1, 1 = receiver: dominant on the last EOF bit is overload, not form error; 0 = transmitter: every EOF bit is checked.
- CNT_W, 8, width of the error counter.

Ports:
- Clock_TB, input, 1, system clock; all logic on the rising edge.
- Reset, input, 1, asynchronous, active-high reset.
- Bit_Entrada, input, 1, received bus bit (0 = dominant).
- Estado, input, [0:5], current decoder state code.
- Clear, input, 1, synchronous clear of `Form_sticky` and `Error_count`.
- Form_monitor, output, 1, one-cycle pulse on a form error.
- Form_field, output, 2, field of the last error: 00 none, 01 CRC delim, 10 ACK delim, 11 EOF; held until the next error or `Clear`.
- Form_sticky, output, 1, set on any form error, held until `Clear`.
- Overload_flag, output, 1, one-cycle pulse: dominant on the last EOF bit (RX_MODE=1 only).
- Eof_bit_idx, output, 3, current EOF bit index (0..EOF_BITS-1).
- Error_count, output, CNT_W, saturating form-error count; present only with FORM_ERR_COUNT_EN.

Behaviour:
- **Reset** (async, active-high): all outputs and internal registers go to 0; `Estado_q` goes to 0.
- **Bit phase**:
  - `Estado_q` registers `Estado` every cycle.
  - phase = 0 when Estado != Estado_q, otherwise `bit_cnt`.
  - `bit_cnt` next = phase+1, wrapping to 0 after CLKS_PER_BIT-1.
  - A state change mid-bit restarts the phase.
- **Sample**: occurs when phase == SAMPLE_POINT. Only one sample per bit.
- **Checked states**: EST_CRC_DELIM, EST_ACK_DELIM, EST_EOF. All other states never produce errors.
- **Error condition**: a sample in a checked state with Bit_Entrada == 0. Exception: RX_MODE=1, state EST_EOF and Eof_bit_idx == EOF_BITS-1.
- **Error response**: registered, so visible on the cycle after the sample:
  - Form_monitor = 1 for exactly one cycle.
  - Form_field is updated.
  - Form_sticky is set.
  - Count increments, saturating at all-ones.
- **Overload exception**: that case instead pulses Overload_flag for one cycle after the sample, with no form error.
- **EOF index**:
  - Resets to 0 whenever Estado != EST_EOF.
  - While in EOF, increments when phase == CLKS_PER_BIT-1.
  - Saturates at EOF_BITS-1.
- **Clear**: zeroes Form_sticky, Form_field and the count. If an error registers in the same cycle, the error wins: sticky = 1, field = new code, count = 1.
- **Recessive samples**: produce no pulse and leave held outputs unchanged.
- **Reset mid-bit**: the phase restarts from the next Estado compare; no pending pulse survives.

Optional Feature:
- FORM_ERR_COUNT_EN
  - Defined: the `Error_count` port and CNT_W-bit saturating counter are built, behaving as above.
  - Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
All scenarios use default parameters unless noted.
1. Estado=9 for 10 cycles, Bit_Entrada=0 from cycle 0 -> Form_monitor high only at cycle 8, Form_field=01, Form_sticky=1.
2. Estado=10, Bit_Entrada=1 for all cycles except cycle 7 (0) -> error pulse at cycle 8, Form_field=10. Then repeat with 0 at cycle 6 only -> no error.
3. Estado=20 for 70 cycles, bit 3 dominant at its sample (cycle 37) -> pulse at cycle 38, Form_field=11, Eof_bit_idx=3 at that time. Bit 6 dominant -> Overload_flag at cycle 68, no Form_monitor.
4. RX_MODE=0, same EOF stimulus with only bit 6 dominant -> Form_monitor at cycle 68, no Overload_flag.
5. CNT_W=2 with FORM_ERR_COUNT_EN, 5 errors -> Error_count = 1, 2, 3, 3, 3. Clear coincident with 6th error -> count=1, sticky=1.
6. Reset asserted at cycle 4 of a dominant CRC-delimiter bit, released at cycle 5 -> all outputs 0 immediately. Next error only after a full new phase sequence (Estado change).
